// File: rtl/regfile_multiport.sv
// GPR file: 2 combinational read ports, 1 byte-enabled write port, XCHG swap, IP and masked flags.
// Latency: reads 0 cycles; all updates visible the cycle after they are issued.
// Backpressure: none, every enable is a single-cycle pulse accepted unconditionally.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_WRITE_BYPASS_EN.
module regfile_multiport #(
    parameter int                WIDTH     = 16,
    parameter int                NUM_REGS  = 4,
    parameter int                SEL_W     = $clog2(NUM_REGS),
    parameter int                FLAG_BITS = 2,
    parameter logic [WIDTH-1:0]  RESET_IP  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SEL_W-1:0]     rd_a_sel,
    output logic [WIDTH-1:0]     rd_a_data,
    input  logic [SEL_W-1:0]     rd_b_sel,
    output logic [WIDTH-1:0]     rd_b_data,
    input  logic                 wr_en,
    input  logic [SEL_W-1:0]     wr_sel,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [WIDTH/8-1:0]   wr_byte_en,
    input  logic                 xchg_en,
    input  logic [SEL_W-1:0]     xchg_sel_a,
    input  logic [SEL_W-1:0]     xchg_sel_b,
    input  logic                 ip_load,
    input  logic [WIDTH-1:0]     ip_load_val,
    input  logic                 ip_inc,
    input  logic [3:0]           ip_inc_amt,
    output logic [WIDTH-1:0]     ip_out,
    input  logic [FLAG_BITS-1:0] flags_we_mask,
    input  logic [FLAG_BITS-1:0] flags_in,
    output logic [FLAG_BITS-1:0] flags_out
);

    localparam int NBYTES = WIDTH / 8;

    logic [WIDTH-1:0]     gpr_q [NUM_REGS];
    logic [WIDTH-1:0]     gpr_d [NUM_REGS];
    logic [WIDTH-1:0]     wr_merged;
    logic [WIDTH-1:0]     ip_q;
    logic [WIDTH-1:0]     ip_d;
    logic [FLAG_BITS-1:0] flags_q;
    logic [FLAG_BITS-1:0] flags_d;

    // Stored value of the write target with the enabled bytes replaced.
    always_comb begin
        wr_merged = gpr_q[wr_sel];
        for (int i = 0; i < NBYTES; i++) begin
            if (wr_byte_en[i]) begin
                wr_merged[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    // Swap first, then the byte write lands on top of the swapped contents.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            gpr_d[r] = gpr_q[r];
        end
        if (xchg_en) begin
            gpr_d[xchg_sel_a] = gpr_q[xchg_sel_b];
            gpr_d[xchg_sel_b] = gpr_q[xchg_sel_a];
        end
        if (wr_en) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wr_byte_en[i]) begin
                    gpr_d[wr_sel][8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        ip_d = ip_q;
        if (ip_load) begin
            ip_d = ip_load_val;
        end else if (ip_inc) begin
            ip_d = ip_q + {{(WIDTH-4){1'b0}}, ip_inc_amt};
        end
    end

    assign flags_d = (flags_q & ~flags_we_mask) | (flags_in & flags_we_mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                gpr_q[r] <= '0;
            end
            ip_q    <= RESET_IP;
            flags_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                gpr_q[r] <= gpr_d[r];
            end
            ip_q    <= ip_d;
            flags_q <= flags_d;
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    // Forward only the byte-write result; swap results are never forwarded.
    assign rd_a_data = (wr_en && (rd_a_sel == wr_sel)) ? wr_merged : gpr_q[rd_a_sel];
    assign rd_b_data = (wr_en && (rd_b_sel == wr_sel)) ? wr_merged : gpr_q[rd_b_sel];
`else
    logic unused_merged;
    assign unused_merged = ^wr_merged;
    assign rd_a_data = gpr_q[rd_a_sel];
    assign rd_b_data = gpr_q[rd_b_sel];
`endif

    assign ip_out    = ip_q;
    assign flags_out = flags_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport with hand-computed expected values.
module tb_regfile_multiport;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rd_a_sel, rd_b_sel, wr_sel, xchg_sel_a, xchg_sel_b;
    logic [15:0] rd_a_data, rd_b_data, wr_data, ip_load_val, ip_out;
    logic [1:0]  wr_byte_en, flags_we_mask, flags_in, flags_out;
    logic        wr_en, xchg_en, ip_load, ip_inc;
    logic [3:0]  ip_inc_amt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_multiport dut (
        .clk           (clk),
        .reset         (reset),
        .rd_a_sel      (rd_a_sel),
        .rd_a_data     (rd_a_data),
        .rd_b_sel      (rd_b_sel),
        .rd_b_data     (rd_b_data),
        .wr_en         (wr_en),
        .wr_sel        (wr_sel),
        .wr_data       (wr_data),
        .wr_byte_en    (wr_byte_en),
        .xchg_en       (xchg_en),
        .xchg_sel_a    (xchg_sel_a),
        .xchg_sel_b    (xchg_sel_b),
        .ip_load       (ip_load),
        .ip_load_val   (ip_load_val),
        .ip_inc        (ip_inc),
        .ip_inc_amt    (ip_inc_amt),
        .ip_out        (ip_out),
        .flags_we_mask (flags_we_mask),
        .flags_in      (flags_in),
        .flags_out     (flags_out)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset         = 1'b0;
        wr_en         = 1'b0;
        wr_byte_en    = 2'b00;
        xchg_en       = 1'b0;
        ip_load       = 1'b0;
        ip_inc        = 1'b0;
        flags_we_mask = 2'b00;
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [15:0] d, input logic [1:0] be);
        wr_en      = 1'b1;
        wr_sel     = sel;
        wr_data    = d;
        wr_byte_en = be;
    endtask

    task automatic rd_a(input logic [1:0] sel);
        rd_a_sel = sel;
        #1;
    endtask

    initial begin
        rd_a_sel = 0; rd_b_sel = 0; wr_sel = 0; wr_data = 0;
        xchg_sel_a = 0; xchg_sel_b = 0; ip_load_val = 0; ip_inc_amt = 0; flags_in = 0;
        idle();
        reset = 1'b1;
        tick();
        idle();

        // Preload everything to all-ones
        ip_load = 1'b1; ip_load_val = 16'hFFFF;
        flags_we_mask = 2'b11; flags_in = 2'b11;
        for (int r = 0; r < 4; r++) begin
            wr(r[1:0], 16'hFFFF, 2'b11);
            tick();
            ip_load = 1'b0; flags_we_mask = 2'b00;
        end
        idle();
        rd_a(2'd3);
        chk("preload_r3", rd_a_data, 16'hFFFF);
        chk("preload_ip", ip_out, 16'hFFFF);
        chk("preload_flags", {14'd0, flags_out}, 16'h0003);

        // Reset overrides concurrent write, IP and flag updates
        reset = 1'b1;
        wr(2'd0, 16'h1234, 2'b11);
        ip_inc = 1'b1; ip_inc_amt = 4'd3;
        flags_we_mask = 2'b11; flags_in = 2'b01;
        tick();
        idle();
        for (int r = 0; r < 4; r++) begin
            rd_a(r[1:0]);
            chk($sformatf("reset_r%0d", r), rd_a_data, 16'h0000);
        end
        rd_b_sel = 2'd0; #1;
        chk("reset_rdb_r0", rd_b_data, 16'h0000);
        chk("reset_ip", ip_out, 16'h0000);
        chk("reset_flags", {14'd0, flags_out}, 16'h0000);

        // Byte-enabled writes
        wr(2'd1, 16'h1234, 2'b11); tick(); idle();
        wr(2'd1, 16'hABCD, 2'b10); tick(); idle();
        rd_a_sel = 2'd1; rd_b_sel = 2'd2; #1;
        chk("bytewr_r1_a", rd_a_data, 16'hAB34);
        chk("bytewr_r2_b", rd_b_data, 16'h0000);
        wr(2'd1, 16'hFFFF, 2'b00); tick(); idle();
        chk("bytewr_noop", rd_a_data, 16'hAB34);
        rd_b_sel = 2'd1; #1;
        chk("same_sel_b", rd_b_data, 16'hAB34);
        wr(2'd1, 16'h5678, 2'b01); tick(); idle();
        chk("bytewr_low", rd_a_data, 16'hAB78);

        // XCHG alone, swap back, then XCHG combined with a byte write
        wr(2'd0, 16'h1111, 2'b11); tick(); idle();
        wr(2'd3, 16'h3333, 2'b11); tick(); idle();
        xchg_en = 1'b1; xchg_sel_a = 2'd0; xchg_sel_b = 2'd3; tick(); idle();
        rd_a_sel = 2'd0; rd_b_sel = 2'd3; #1;
        chk("xchg_r0", rd_a_data, 16'h3333);
        chk("xchg_r3", rd_b_data, 16'h1111);
        xchg_en = 1'b1; xchg_sel_a = 2'd3; xchg_sel_b = 2'd0; tick(); idle();
        chk("xchg_back_r0", rd_a_data, 16'h1111);
        chk("xchg_back_r3", rd_b_data, 16'h3333);
        xchg_en = 1'b1; xchg_sel_a = 2'd0; xchg_sel_b = 2'd3;
        wr(2'd3, 16'h00FF, 2'b01);
        tick(); idle();
        chk("xchgwr_r0", rd_a_data, 16'h3333);
        chk("xchgwr_r3", rd_b_data, 16'h11FF);
        xchg_en = 1'b1; xchg_sel_a = 2'd1; xchg_sel_b = 2'd1; tick(); idle();
        rd_a(2'd1);
        chk("xchg_same", rd_a_data, 16'hAB78);

        // IP load / increment / wrap / priority
        ip_load = 1'b1; ip_load_val = 16'hFFFE; tick(); idle();
        chk("ip_load", ip_out, 16'hFFFE);
        ip_inc = 1'b1; ip_inc_amt = 4'd5; tick(); idle();
        chk("ip_wrap", ip_out, 16'h0003);
        ip_load = 1'b1; ip_load_val = 16'h0100; ip_inc = 1'b1; ip_inc_amt = 4'd7; tick(); idle();
        chk("ip_load_prio", ip_out, 16'h0100);
        tick();
        chk("ip_hold", ip_out, 16'h0100);
        ip_inc = 1'b1; ip_inc_amt = 4'd15; tick(); idle();
        chk("ip_inc15", ip_out, 16'h010F);
        ip_inc = 1'b1; ip_inc_amt = 4'd0; tick(); idle();
        chk("ip_inc0", ip_out, 16'h010F);

        // Masked flags
        flags_we_mask = 2'b10; flags_in = 2'b11; tick(); idle();
        chk("flags_cf", {14'd0, flags_out}, 16'h0002);
        flags_we_mask = 2'b01; flags_in = 2'b01; tick(); idle();
        chk("flags_zf", {14'd0, flags_out}, 16'h0003);
        flags_we_mask = 2'b10; flags_in = 2'b00; tick(); idle();
        chk("flags_clr_cf", {14'd0, flags_out}, 16'h0001);
        flags_we_mask = 2'b00; flags_in = 2'b10; tick(); idle();
        chk("flags_nomask", {14'd0, flags_out}, 16'h0001);

        // Same-cycle read of the write target
        rd_a_sel = 2'd2; rd_b_sel = 2'd1;
        wr(2'd2, 16'h5A5A, 2'b01); #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        chk("byp_partial", rd_a_data, 16'h005A);
`else
        chk("byp_partial", rd_a_data, 16'h0000);
`endif
        chk("byp_other_port", rd_b_data, 16'hAB78);
        wr_byte_en = 2'b11; #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        chk("byp_full", rd_a_data, 16'h5A5A);
`else
        chk("byp_full", rd_a_data, 16'h0000);
`endif
        tick(); idle();
        chk("byp_next_cycle", rd_a_data, 16'h5A5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised general-purpose register file for the minimal x86 datapath. It provides two independent combinational read ports and one byte-enabled write port, which supports AL/AH-style partial writes. It also holds a single-cycle XCHG swap path, the instruction pointer with load/increment logic, and a masked flags register. It sits between the decoder/ALU and writeback, and replaces the single-port 4×16 register file.

## Interface
- `WIDTH`, 16: register width in bits; must be a multiple of 8.
- `NUM_REGS`, 4: number of general-purpose registers; power of two, ≥2.
- `SEL_W`, $clog2(NUM_REGS): register select width (derived).
- `FLAG_BITS`, 2: flags width; bit 0 = ZF, bit 1 = CF, higher bits are generic.
- `RESET_IP`, 0: IP value after reset.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rd_a_sel`  in  SEL_W  read port A select.
- `rd_a_data`  out  WIDTH  read port A data.
- `rd_b_sel`  in  SEL_W  read port B select.
- `rd_b_data`  out  WIDTH  read port B data.
- `wr_en`  in  1  write enable.
- `wr_sel`  in  SEL_W  write register select.
- `wr_data`  in  WIDTH  write data.
- `wr_byte_en`  in  WIDTH/8  per-byte write enable; bit i covers bits [8i+7:8i].
- `xchg_en`  in  1  swap registers `xchg_sel_a` and `xchg_sel_b`.
- `xchg_sel_a`, `xchg_sel_b`  in  SEL_W  swap operands.
- `ip_load`  in  1  load IP from `ip_load_val`.
- `ip_load_val`  in  WIDTH  new IP value.
- `ip_inc`  in  1  add `ip_inc_amt` to IP.
- `ip_inc_amt`  in  4  increment amount, 0–15 (instruction length).
- `ip_out`  out  WIDTH  current IP.
- `flags_we_mask`  in  FLAG_BITS  per-flag update enable.
- `flags_in`  in  FLAG_BITS  new flag values.
- `flags_out`  out  FLAG_BITS  current flags.

## Operation
- Reset, checked every cycle with `reset`=1:
  - all GPRs = 0; IP = `RESET_IP`; flags = 0.
  - `rd_*_data` reflect zeroed registers; `ip_out` = `RESET_IP`; `flags_out` = 0.
  - Reset overrides every other input in the same cycle.
- Reads: `rd_x_data` = GPR[`rd_x_sel`], combinational. Both ports may select the same register.
- Write: if `wr_en`, then for each i with `wr_byte_en[i]`=1, GPR[`wr_sel`] byte i ← `wr_data` byte i. Disabled bytes hold. `wr_en`=1 with `wr_byte_en`=0 is a no-op.
- XCHG: if `xchg_en`, GPR[a] ← old GPR[b] and GPR[b] ← old GPR[a], both from pre-edge values. When a == b the register is unchanged.
- Write/XCHG same cycle:
  - XCHG is applied first.
  - The byte-enabled write then overrides its enabled bytes of GPR[`wr_sel`], even if `wr_sel` is an XCHG operand.
- IP:
  - `ip_load` beats `ip_inc`.
  - Increment is IP + zero-extended `ip_inc_amt`, modulo 2^WIDTH (wraps silently).
  - Neither asserted: IP holds.
- Flags: for each bit with `flags_we_mask`=1, flag ← `flags_in`. Other bits hold.
- No internal state machine beyond register state; all updates are independent per cycle.

## Timing
- Read latency: 0 cycles (combinational from sel to data).
- A write, XCHG, IP or flag update issued in cycle N is visible on the outputs in cycle N+1.
- Without bypass, a same-cycle read of a register being written returns the old value.
- No handshakes; every enable is a single-cycle pulse and may be held for back-to-back updates.

## Configuration
- `REGFILE_WRITE_BYPASS_EN` defined:
  - a read port whose select equals `wr_sel` while `wr_en`=1 returns the merged value combinationally in the same cycle.
  - The merged value is the enabled bytes from `wr_data` plus the other bytes from the stored register.
  - XCHG results are not bypassed.
- Undefined: reads always return the stored (pre-edge) value; there is no path from `wr_data` to `rd_*_data`.

## Test plan
- Reset: preload all regs with 16'hFFFF, assert `reset` for 1 cycle. All GPRs read 0, `ip_out`=`RESET_IP`, `flags_out`=0.
- Byte write: R1=16'h1234, then write `wr_data`=16'hABCD with `wr_byte_en`=2'b10. R1=16'hAB34; port A on R1 and port B on R2 read concurrently and correctly.
- XCHG plus write:
  - R0=16'h1111, R3=16'h3333; `xchg_en` on (0,3) → R0=16'h3333, R3=16'h1111.
  - Same cycle also writing R3=16'h00FF with byte_en 2'b01 → R3=16'h11FF.
- IP: IP=16'hFFFE, `ip_inc` with amt 5 → 16'h0003. `ip_load`=16'h0100 together with `ip_inc` → 16'h0100.
- Flags: flags=2'b00, mask 2'b10, in 2'b11 → flags=2'b10.
- Bypass: R2=16'h0000, write 16'h5A5A to R2 with port A on R2.
  - Bypass macro defined: port A shows 16'h5A5A in the same cycle.
  - Undefined: 16'h0000 until the next cycle.
